// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the producer agents, the FIFO write port and the write arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            done;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          fifo_wr_ack;
    logic                          fifo_overflow;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic                          busy;
    logic [7:0]                    retry_cnt;
    logic                          proto_err;

    // Arbiter side
    modport master (
        input  req, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
        output done, gnt, fifo_wr_en, fifo_data_in, busy, retry_cnt, proto_err
    );

    // Producer / FIFO side
    modport slave (
        output req, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
        input  done, gnt, fifo_wr_en, fifo_data_in, busy, retry_cnt, proto_err
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Each write runs IDLE (grant) -> ISSUE (wr_en high) -> WAIT (judge response);
// an overflowed write is locked and re-issued for the same owner.
module fifo_wr_arbiter #(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 16,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input logic               clk,
    input logic               rst_n,
    fifo_wr_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       last;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       pick;
    logic [DATA_WIDTH-1:0]  pick_data;
    logic                   lock;
    logic [NUM_REQ-1:0]     gnt;
    logic [NUM_REQ-1:0]     done;
    logic                   wr_en;
    logic [DATA_WIDTH-1:0]  data;
    logic                   busy;
    logic [7:0]             retry_cnt;
    logic                   proto_err;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // First asserted request after 'from' in rotation; scanned backwards so the
    // nearest candidate is the one that sticks.
    function automatic logic [IDX_W-1:0] next_owner(input logic [NUM_REQ-1:0] r,
                                                    input logic [IDX_W-1:0]   from);
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] ci;
        int               c;
        sel = from;
        for (int k = NUM_REQ; k >= 1; k--) begin
            c  = (int'(from) + k) % NUM_REQ;
            ci = IDX_W'(c);
            if (r[ci]) sel = ci;
        end
        return sel;
    endfunction

    // Candidate owner and its data slice for the next grant decision
    always_comb begin
        pick      = next_owner(bus.req, last);
        pick_data = DATA_WIDTH'(bus.req_data >> (DATA_WIDTH * int'(pick)));
    end

    // Write sequencer: grant, issue, judge the FIFO response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= IDX_W'(NUM_REQ - 1);
            owner     <= '0;
            lock      <= 1'b0;
            gnt       <= '0;
            done      <= '0;
            wr_en     <= 1'b0;
            data      <= '0;
            busy      <= 1'b0;
            retry_cnt <= 8'd0;
            proto_err <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    // A locked retry reuses owner and data already held in 'data'
                    if (!bus.fifo_full && (lock || (|bus.req))) begin
                        if (!lock) begin
                            owner <= pick;
                            gnt   <= one_hot(pick);
                            data  <= pick_data;
                        end
                        wr_en <= 1'b1;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    wr_en <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (bus.fifo_overflow && !bus.fifo_wr_ack) begin
                        lock      <= 1'b1;
                        retry_cnt <= sat_inc(retry_cnt);
                    end else begin
                        // Neither or both flags is a FIFO protocol fault; complete anyway
                        if (bus.fifo_overflow == bus.fifo_wr_ack) proto_err <= 1'b1;
                        done <= one_hot(owner);
                        last <= owner;
                        lock <= 1'b0;
                        gnt  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt          = gnt;
    assign bus.done         = done;
    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_data_in = data;
    assign bus.busy         = busy;
    assign bus.retry_cnt    = retry_cnt;
    assign bus.proto_err    = proto_err;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized bench for fifo_wr_arbiter with a transaction-level model.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 16;

    logic clk;
    logic rst_n;
    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // FIFO responder state: response codes {ack,ovf}, default is a clean ack
    logic [1:0] resp_q[$];
    logic       pend;

    // Values presented at the coming clock edge
    logic            full_e;
    logic [NR-1:0]   req_e;
    logic [NR*DW-1:0] data_e;

    // Reference model
    int          m_last, m_owner, m_cd, m_retry;
    logic        m_lock, m_proto;
    logic [1:0]  m_resp;
    logic [DW-1:0] m_data;

    int stepn;
    int wr1;
    int done_idx[$];
    int done_at[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] v;
        v = '0;
        if (i >= 0) v = NR'(1) << i;
        return v;
    endfunction

    function automatic int rr(input int last, input logic [NR-1:0] r);
        for (int k = 1; k <= NR; k++)
            if (r[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    function automatic logic [DW-1:0] slice(input logic [NR*DW-1:0] d, input int i);
        logic [NR*DW-1:0] t;
        t = d >> (i * DW);
        return t[DW-1:0];
    endfunction

    task automatic model_reset();
        m_last = NR - 1; m_owner = 0; m_cd = 0; m_retry = 0;
        m_lock = 1'b0; m_proto = 1'b0; m_resp = 2'b00; m_data = '0;
        pend = 1'b0;
        resp_q.delete();
        done_idx.delete();
        done_at.delete();
    endtask

    // Timeline per write: issue cycle, wait cycle, outcome cycle.
    task automatic model_check();
        logic          ew;
        logic [NR-1:0] ed;
        logic [NR-1:0] eg;
        ew = 1'b0;
        ed = '0;
        if (m_cd == 2) begin
            m_cd   = 1;
            m_resp = {bus.fifo_wr_ack, bus.fifo_overflow};
        end else if (m_cd == 1) begin
            m_cd = 0;
            if (m_resp == 2'b01) begin
                m_lock = 1'b1;
                if (m_retry < 255) m_retry++;
            end else begin
                if (m_resp != 2'b10) m_proto = 1'b1;
                ed     = oh(m_owner);
                m_last = m_owner;
                m_lock = 1'b0;
            end
        end else if (!full_e && (m_lock || req_e != '0)) begin
            if (!m_lock) begin
                m_owner = rr(m_last, req_e);
                m_data  = slice(data_e, m_owner);
            end
            ew   = 1'b1;
            m_cd = 2;
        end
        eg = (m_cd != 0 || m_lock) ? oh(m_owner) : '0;
        check("wr_en",     32'(bus.fifo_wr_en),   32'(ew));
        check("gnt",       32'(bus.gnt),          32'(eg));
        check("done",      32'(bus.done),         32'(ed));
        check("busy",      32'(bus.busy),         32'(m_cd != 0));
        check("data_in",   32'(bus.fifo_data_in), 32'(m_data));
        check("retry_cnt", 32'(bus.retry_cnt),    32'(m_retry));
        check("proto_err", 32'(bus.proto_err),    32'(m_proto));
    endtask

    task automatic step();
        logic [1:0] code;
        full_e = bus.fifo_full;
        req_e  = bus.req;
        data_e = bus.req_data;
        @(posedge clk);
        #1;
        stepn++;
        if (pend) begin
            code = 2'b10;
            if (resp_q.size() != 0) code = resp_q.pop_front();
            bus.fifo_wr_ack   = code[1];
            bus.fifo_overflow = code[0];
        end else begin
            bus.fifo_wr_ack   = 1'b0;
            bus.fifo_overflow = 1'b0;
        end
        pend = bus.fifo_wr_en;
        if (bus.fifo_wr_en && bus.gnt == 4'b0010) wr1++;
        for (int i = 0; i < NR; i++)
            if (bus.done[i]) begin
                done_idx.push_back(i);
                done_at.push_back(stepn);
            end
        model_check();
    endtask

    task automatic reset_dut();
        bus.req = '0; bus.fifo_full = 1'b0;
        bus.fifo_wr_ack = 1'b0; bus.fifo_overflow = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_gnt",   32'(bus.gnt),          32'd0);
        check("rst_done",  32'(bus.done),         32'd0);
        check("rst_wr_en", 32'(bus.fifo_wr_en),   32'd0);
        check("rst_data",  32'(bus.fifo_data_in), 32'd0);
        check("rst_busy",  32'(bus.busy),         32'd0);
        check("rst_retry", 32'(bus.retry_cnt),    32'd0);
        check("rst_proto", 32'(bus.proto_err),    32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.req = '0;
        bus.fifo_full = 1'b0;
        while ((m_cd != 0 || m_lock) && n < 60) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(m_cd != 0 || m_lock), 32'd0);
    endtask

    initial begin
        int exp2[6];
        exp2 = '{0, 1, 2, 3, 0, 1};
        stepn = 0; wr1 = 0;
        bus.req_data = '0;

        // Single request from requester 2
        reset_dut();
        bus.req_data = {16'h1111, 16'hA5A5, 16'h2222, 16'h3333};
        bus.req = 4'b0100;
        step();
        check("t1_gnt",  32'(bus.gnt),          32'h4);
        check("t1_data", 32'(bus.fifo_data_in), 32'hA5A5);
        bus.req = '0;
        step();
        step();
        check("t1_done", 32'(bus.done), 32'h4);
        check("t1_busy", 32'(bus.busy), 32'd0);
        step();

        // All four requesting, FIFO always acks
        reset_dut();
        bus.req_data = {$urandom, $urandom};
        bus.req = 4'b1111;
        for (int n = 0; n < 40 && done_idx.size() < 6; n++) step();
        check("t2_timeout", 32'(done_idx.size() >= 6), 32'd1);
        if (done_idx.size() >= 6)
            for (int i = 0; i < 6; i++) begin
                check("t2_order", 32'(done_idx[i]), 32'(exp2[i]));
                if (i > 0) check("t2_gap", 32'(done_at[i] - done_at[i-1]), 32'd3);
            end
        drain();

        // FIFO full blocks grants; requester 0 first once it clears
        reset_dut();
        bus.req_data = {$urandom, $urandom};
        bus.fifo_full = 1'b1;
        bus.req = 4'b0011;
        for (int n = 0; n < 10; n++) step();
        bus.fifo_full = 1'b0;
        for (int n = 0; n < 20 && done_idx.size() < 1; n++) step();
        check("t3_timeout", 32'(done_idx.size() >= 1), 32'd1);
        if (done_idx.size() >= 1) check("t3_first", 32'(done_idx[0]), 32'd0);
        drain();

        // Overflow twice for requester 1 while requester 0 waits
        reset_dut();
        bus.req_data = {$urandom, $urandom};
        bus.req = 4'b0001;
        for (int n = 0; n < 10 && done_idx.size() < 1; n++) step();
        bus.req = '0;
        step();
        done_idx.delete();
        resp_q.push_back(2'b01);
        resp_q.push_back(2'b01);
        wr1 = 0;
        bus.req = 4'b0011;
        for (int n = 0; n < 40 && done_idx.size() < 2; n++) step();
        check("t4_timeout", 32'(done_idx.size() >= 2), 32'd1);
        if (done_idx.size() >= 2) begin
            check("t4_first",  32'(done_idx[0]), 32'd1);
            check("t4_second", 32'(done_idx[1]), 32'd0);
        end
        check("t4_wr1",   32'(wr1),           32'd3);
        check("t4_retry", 32'(bus.retry_cnt), 32'd2);
        drain();

        // Randomized traffic with random full and overflow responses
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(3) == 0) bus.req = NR'($urandom);
            if ($urandom_range(7) == 0) bus.req_data = {$urandom, $urandom};
            bus.fifo_full = ($urandom_range(4) == 0);
            if (resp_q.size() < 2) resp_q.push_back(($urandom_range(3) == 0) ? 2'b01 : 2'b10);
            step();
        end
        resp_q.delete();
        drain();

        // Retry counter saturation
        for (int n = 0; n < 260; n++) resp_q.push_back(2'b01);
        bus.req = 4'b0001;
        for (int n = 0; n < 1000 && resp_q.size() != 0; n++) step();
        check("sat_timeout", 32'(resp_q.size()), 32'd0);
        drain();
        check("sat_retry", 32'(bus.retry_cnt), 32'd255);

        // Protocol error: both flags, then neither flag
        done_idx.delete();
        resp_q.push_back(2'b11);
        resp_q.push_back(2'b00);
        bus.req = 4'b0100;
        for (int n = 0; n < 20 && done_idx.size() < 2; n++) step();
        check("pe_timeout", 32'(done_idx.size() >= 2), 32'd1);
        check("pe_sticky",  32'(bus.proto_err), 32'd1);
        drain();
        for (int n = 0; n < 3; n++) step();
        check("pe_hold", 32'(bus.proto_err), 32'd1);

        // Reset in the WAIT cycle of a write for requester 3
        bus.req = 4'b1000;
        step();
        bus.req = 4'b1001;
        step();
        check("mid_busy", 32'(bus.busy), 32'd1);
        reset_dut();
        bus.req = 4'b1001;
        for (int n = 0; n < 20 && done_idx.size() < 2; n++) step();
        check("mid_timeout", 32'(done_idx.size() >= 2), 32'd1);
        if (done_idx.size() >= 2) begin
            check("mid_first",  32'(done_idx[0]), 32'd0);
            check("mid_second", 32'(done_idx[1]), 32'd3);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
